// File: rtl/spi_slave_duplex.sv
// Full-duplex SPI slave. Every SPI input is oversampled in the user_clk
// domain, so no flop is clocked by sclk. Received words appear on o_rx_data
// with an o_rx_evt strobe. Transmit words are taken through a one-entry
// holding register that uses a ready/valid handshake.
module spi_slave_duplex #(
  parameter logic                  MCS_VALID_LEVEL = 1'b0,
  parameter logic [1:0]            SCK_MODE        = 2'b10,
  parameter logic                  DATA_ENDIAN     = 1'b1,
  parameter int                    DATA_WIDTH      = 16,
  parameter logic [DATA_WIDTH-1:0] TX_IDLE_WORD    = '0
) (
  input  logic                  user_clk,
  input  logic                  user_rst,
  input  logic                  i_tx_valid,
  input  logic [DATA_WIDTH-1:0] i_tx_data,
  output logic                  o_tx_ready,
  output logic                  o_rx_evt,
  output logic [DATA_WIDTH-1:0] o_rx_data,
  output logic                  o_tx_underrun,
  output logic                  o_frame_err,
  input  logic                  mcs,
  input  logic                  sclk,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe
);

  localparam logic CPOL = SCK_MODE[1];
  localparam logic CPHA = SCK_MODE[0];
  localparam int   CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT} state_t;

  state_t state, state_nxt;

  logic [2:0] mcs_sr;
  logic [2:0] sclk_sr;
  logic [1:0] mosi_sr;

  logic                  hold_full;
  logic [DATA_WIDTH-1:0] hold_data;
  logic [DATA_WIDTH-1:0] tx_shreg;
  logic [DATA_WIDTH-1:0] rx_shreg;
  logic [CNT_W-1:0]      bit_cnt;

  logic mcs_act, mcs_rise;
  logic lead_edge, trail_edge, sample_edge, shift_edge;
  logic load_en, sample_en, shift_en, word_done, abort, tx_clear, tx_accept;
  logic [DATA_WIDTH-1:0] load_word;

  // Two synchroniser stages plus one edge-detect stage per SPI input.
  // The mcs chain resets to the active level. A chip select that is still
  // held across reset therefore does not look like a fresh activation, and
  // the block waits for mcs to go inactive and then active again.
  always_ff @(posedge user_clk or posedge user_rst) begin
    // NOTE: sequential state always uses non-blocking assignments, so every
    // flop samples the pre-edge values regardless of statement order.
    if (user_rst) begin
      mcs_sr  <= {3{MCS_VALID_LEVEL}};
      sclk_sr <= {3{CPOL}};
      mosi_sr <= '0;
    end else begin
      mcs_sr  <= {mcs_sr[1:0], mcs};
      sclk_sr <= {sclk_sr[1:0], sclk};
      mosi_sr <= {mosi_sr[0], mosi};
    end
  end

  assign mcs_act     = (mcs_sr[1] == MCS_VALID_LEVEL);
  assign mcs_rise    = mcs_act && (mcs_sr[2] != MCS_VALID_LEVEL);
  assign lead_edge   = (sclk_sr[2] == CPOL) && (sclk_sr[1] != CPOL);
  assign trail_edge  = (sclk_sr[2] != CPOL) && (sclk_sr[1] == CPOL);
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge : trail_edge;

  assign tx_accept  = i_tx_valid && !hold_full;
  assign o_tx_ready = !hold_full;
  assign load_word  = hold_full ? hold_data : TX_IDLE_WORD;
  assign tx_clear   = abort || (load_en && !mcs_act);
  assign miso       = DATA_ENDIAN ? tx_shreg[DATA_WIDTH-1] : tx_shreg[0];
  assign miso_oe    = (state != S_IDLE);

  // FSM state register.
  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state decode and per-cycle datapath strobes.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_nxt = state;
    load_en   = 1'b0;
    sample_en = 1'b0;
    shift_en  = 1'b0;
    word_done = 1'b0;
    abort     = 1'b0;
    case (state)
      S_IDLE: if (mcs_rise) state_nxt = S_LOAD;
      S_LOAD: begin
        load_en   = 1'b1;
        state_nxt = mcs_act ? S_SHIFT : S_IDLE;
      end
      S_SHIFT: begin
        if (bit_cnt == CNT_FULL) begin
          word_done = 1'b1;
          state_nxt = S_LOAD;
        end else if (!mcs_act) begin
          abort     = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          sample_en = sample_edge;
          // Shift only after at least one sample. This skips the first
          // leading edge when CPHA=1, and the trailing edge that follows the
          // last sample of the previous word when CPHA=0.
          shift_en  = shift_edge && (bit_cnt != '0);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Tx holding register. An offer accepted in the same cycle as a load
  // from an empty register lands here, ready for the next word slot.
  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      hold_full <= 1'b0;
      hold_data <= '0;
    end else begin
      if (tx_accept) begin
        hold_full <= 1'b1;
        hold_data <= i_tx_data;
      end else if (load_en) begin
        hold_full <= 1'b0;
      end
    end
  end

  // Tx shift register. Its head bit drives miso directly.
  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      tx_shreg <= '0;
    end else if (tx_clear) begin
      tx_shreg <= '0;
    end else if (load_en) begin
      tx_shreg <= load_word;
    end else if (shift_en) begin
      if (DATA_ENDIAN) tx_shreg <= {tx_shreg[DATA_WIDTH-2:0], 1'b0};
      else             tx_shreg <= {1'b0, tx_shreg[DATA_WIDTH-1:1]};
    end
  end

  // Rx shift register and the count of bits sampled in the current word.
  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      rx_shreg <= '0;
      bit_cnt  <= '0;
    end else begin
      if (load_en || abort) begin
        bit_cnt <= '0;
      end else if (sample_en) begin
        bit_cnt <= bit_cnt + CNT_W'(1);
        if (DATA_ENDIAN) rx_shreg <= {rx_shreg[DATA_WIDTH-2:0], mosi_sr[1]};
        else             rx_shreg <= {mosi_sr[1], rx_shreg[DATA_WIDTH-1:1]};
      end
    end
  end

  // Registered user-facing outputs: the rx word and one-cycle status pulses.
  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      o_rx_evt      <= 1'b0;
      o_rx_data     <= '0;
      o_tx_underrun <= 1'b0;
      o_frame_err   <= 1'b0;
    end else begin
      o_rx_evt      <= word_done;
      o_tx_underrun <= load_en && !hold_full;
      o_frame_err   <= abort && (bit_cnt != '0);
      if (word_done) o_rx_data <= rx_shreg;
    end
  end

endmodule
